// File: rtl/mem_access_unit_if.sv
// Word-wide request/ack/rvalid data bus between the MEM-stage
// load/store unit (master) and on-chip RAM or an SDRAM bridge (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane-aligns stores, extracts and extends
// loads, and stalls the front of the pipeline until the bus access ends.
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_wr,
    input  logic [2:0]  mem_f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold_i,
    output logic        stall_req,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master bus
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RWAIT,
        DONE
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo2_q;

    logic        access;
    logic        is_b;
    logic        is_h;
    logic        mis_n;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [15:0] sh;
    logic [31:0] ext;

    assign access    = mem_re | mem_wr;
    assign stall_req = access & (state != DONE);

    // Reset pulls the request off the bus in the same cycle.
    assign bus.bus_req   = req_q & ~rst;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    // Decode access size, alignment and store lane placement.
    always_comb begin
        is_b  = (mem_f3 == 3'b000) | (mem_f3 == 3'b100);
        is_h  = (mem_f3 == 3'b001) | (mem_f3 == 3'b101);
        mis_n = (is_h & addr[0])
              | ((mem_f3 == 3'b010) & (addr[1:0] != 2'b00));
        be_n  = 4'b1111;
        wd_n  = wdata;
        unique case (1'b1)
            is_b: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{wdata[7:0]}};
            end
            is_h: begin
                be_n = addr[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{wdata[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = wdata;
            end
        endcase
    end

    // Select the addressed byte/half of the read word and extend it.
    always_comb begin
        sh  = 16'(bus.bus_rdata >> {lo2_q, 3'b000});
        ext = bus.bus_rdata;
        unique case (f3_q)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = bus.bus_rdata;
        endcase
    end

    // Access sequencer with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            lo2_q    <= '0;
            ld_data  <= '0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access) begin
                        if (mis_n) begin
                            misalign <= 1'b1;
                            ld_data  <= '0;
                            state    <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= ~mem_re;
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_n;
                            wdata_q <= wd_n;
                            f3_q    <= mem_f3;
                            lo2_q   <= addr[1:0];
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        req_q <= 1'b0;
                        cnt   <= '0;
                        if (we_q) begin
                            state <= DONE;
                        end else if (bus.bus_rvalid) begin
                            ld_data <= ext;
                            state   <= DONE;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (cnt == LAST) begin
                        req_q   <= 1'b0;
                        bus_err <= 1'b1;
                        ld_data <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RWAIT: begin
                    if (bus.bus_rvalid) begin
                        ld_data <= ext;
                        state   <= DONE;
                    end else if (cnt == LAST) begin
                        bus_err <= 1'b1;
                        ld_data <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (!hold_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit with a behavioural
// bus responder and an arithmetic model of lane placement and extension.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_re = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  mem_f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        hold_i = 1'b0;
    logic        stall_req;
    logic [31:0] ld_data;
    logic        misalign;
    logic        bus_err;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_re    (mem_re),
        .mem_wr    (mem_wr),
        .mem_f3    (mem_f3),
        .addr      (addr),
        .wdata     (wdata),
        .hold_i    (hold_i),
        .stall_req (stall_req),
        .ld_data   (ld_data),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int total_n = 0;
    int acc_cnt = 0;
    logic [31:0] exp_ld = '0;

    // Count accepted bus transactions.
    always @(posedge clk) begin
        if (bus.bus_req && bus.bus_ack) acc_cnt <= acc_cnt + 1;
    end

    function automatic int sz_of(logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit mis_of(logic [2:0] f, logic [31:0] a);
        if (f == 3'b010) return (a % 4) != 0;
        if (sz_of(f) == 2) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] be_of(logic [2:0] f, logic [31:0] a);
        int s = sz_of(f);
        if (s == 4) return 4'hF;
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wd_of(logic [2:0] f, logic [31:0] w);
        int s = sz_of(f);
        if (s == 1) return 32'(w[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ld_of(logic [2:0] f, logic [31:0] a,
                                          logic [31:0] r);
        int s = sz_of(f);
        logic [31:0] v;
        if (s == 4) return r;
        v = r >> (8 * (a % 4));
        if (s == 1) begin
            v = v & 32'hFF;
            if (f == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'hFFFF;
            if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic do_access(input bit re, input bit wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] r, input int ackd,
                             input int rvd, input int holdn,
                             input string nm);
        bit mis = mis_of(f, a);
        int c0 = acc_cnt;
        logic [37:0] expb;
        logic [31:0] obs_wd;
        mem_re = re;
        mem_wr = wr;
        mem_f3 = f;
        addr   = a;
        wdata  = w;
        #1;
        total_n++;
        if (stall_req !== 1'b1)
            $display("FAIL %s idle_stall got=%b want=1", nm, stall_req);
        else pass_n++;
        @(posedge clk); #1;
        if (mis) begin
            exp_ld = '0;
            total_n++;
            if ({misalign, stall_req, bus.bus_req, ld_data} !==
                {1'b1, 1'b0, 1'b0, 32'h0})
                $display("FAIL %s misalign got=%b%b%b %h want=100 0",
                         nm, misalign, stall_req, bus.bus_req, ld_data);
            else pass_n++;
        end else begin
            expb = {1'b1, ~re, a & ~32'h3, be_of(f, a)};
            for (int i = 0; i <= ackd; i++) begin
                obs_wd = re ? 32'h0 : bus.bus_wdata;
                total_n++;
                if ({bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be,
                     stall_req, obs_wd} !==
                    {expb, 1'b1, re ? 32'h0 : wd_of(f, w)})
                    $display("FAIL %s req_fields got=%b%b %h %b s=%b %h want=%h wd=%h",
                             nm, bus.bus_req, bus.bus_we, bus.bus_addr,
                             bus.bus_be, stall_req, obs_wd, expb,
                             wd_of(f, w));
                else pass_n++;
                if (i < ackd) begin
                    @(posedge clk); #1;
                end
            end
            bus.bus_ack    = 1'b1;
            bus.bus_rvalid = re ? (rvd == 0) : 1'($urandom % 2);
            bus.bus_rdata  = re ? r : $urandom;
            @(posedge clk); #1;
            bus.bus_ack    = 1'b0;
            bus.bus_rvalid = 1'b0;
            bus.bus_rdata  = $urandom;
            if (re && rvd > 0) begin
                for (int j = 1; j < rvd; j++) begin
                    total_n++;
                    if ({stall_req, bus.bus_req} !== 2'b10)
                        $display("FAIL %s rwait got=%b%b want=10",
                                 nm, stall_req, bus.bus_req);
                    else pass_n++;
                    @(posedge clk); #1;
                end
                bus.bus_rvalid = 1'b1;
                bus.bus_rdata  = r;
                @(posedge clk); #1;
                bus.bus_rvalid = 1'b0;
                bus.bus_rdata  = $urandom;
            end
            if (re) exp_ld = ld_of(f, a, r);
            total_n++;
            if ({stall_req, bus.bus_req, misalign, bus_err, ld_data} !==
                {4'b0000, exp_ld})
                $display("FAIL %s done got=%b%b%b%b %h want=0000 %h",
                         nm, stall_req, bus.bus_req, misalign, bus_err,
                         ld_data, exp_ld);
            else pass_n++;
        end
        for (int k = 0; k < holdn; k++) begin
            hold_i = 1'b1;
            @(posedge clk); #1;
            total_n++;
            if ({stall_req, bus.bus_req, misalign, ld_data} !==
                {3'b000, exp_ld})
                $display("FAIL %s hold got=%b%b%b %h want=000 %h",
                         nm, stall_req, bus.bus_req, misalign, ld_data,
                         exp_ld);
            else pass_n++;
        end
        hold_i = 1'b0;
        mem_re = 1'b0;
        mem_wr = 1'b0;
        @(posedge clk); #1;
        total_n++;
        if ({stall_req, bus.bus_req} !== 2'b00 ||
            (acc_cnt - c0) != (mis ? 0 : 1))
            $display("FAIL %s release got=%b%b acc=%0d want=00 acc=%0d",
                     nm, stall_req, bus.bus_req, acc_cnt - c0,
                     mis ? 0 : 1);
        else pass_n++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total_n++;
        if ({stall_req, misalign, bus_err, ld_data, bus.bus_req,
             bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !== '0)
            $display("FAIL reset_state got=%b%b%b %h %b%b %h %b %h want=0",
                     stall_req, misalign, bus_err, ld_data, bus.bus_req,
                     bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata);
        else pass_n++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_access(0, 1, 3'b000, 32'h1003, 32'hAB, 32'h0, 2, 0, 0, "sb");
        total_n++;
        if ({bus.bus_addr, bus.bus_be, bus.bus_wdata} !==
            {32'h1000, 4'b1000, 32'hABAB_ABAB})
            $display("FAIL sb_lit got=%h %b %h want=1000 1000 abababab",
                     bus.bus_addr, bus.bus_be, bus.bus_wdata);
        else pass_n++;
        do_access(1, 0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 0, 1, 0, "lb");
        total_n++;
        if (ld_data !== 32'hFFFF_FF80)
            $display("FAIL lb_lit got=%h want=ffffff80", ld_data);
        else pass_n++;
        do_access(1, 0, 3'b100, 32'h2001, 32'h0, 32'h0000_8000, 1, 0, 0, "lbu");
        total_n++;
        if (ld_data !== 32'h0000_0080)
            $display("FAIL lbu_lit got=%h want=00000080", ld_data);
        else pass_n++;
        do_access(1, 0, 3'b001, 32'h2002, 32'h0, 32'h1234_5678, 5, 2, 0, "lh");
        total_n++;
        if (ld_data !== 32'h0000_1234)
            $display("FAIL lh_lit got=%h want=00001234", ld_data);
        else pass_n++;
        do_access(1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 0, "lw_mis");
        do_access(1, 1, 3'b010, 32'h3004, 32'h5555_AAAA, 32'hCAFE_F00D,
                  1, 3, 3, "hold_both");
        do_access(0, 1, 3'b111, 32'h3007, 32'h1357_9BDF, 32'h0, 0, 0, 0, "undef");
    endtask

    task automatic test_timeout;
        int n = 0;
        mem_re = 1'b1;
        mem_f3 = 3'b010;
        addr   = 32'h4000;
        @(posedge clk); #1;
        while (!bus_err && n < 3 * TO) begin
            @(posedge clk); #1;
            n++;
        end
        total_n++;
        if (n != TO || {bus.bus_req, stall_req, ld_data} !== 34'h0)
            $display("FAIL timeout got=%0d %b%b %h want=%0d 00 0",
                     n, bus.bus_req, stall_req, ld_data, TO);
        else pass_n++;
        exp_ld = '0;
        mem_re = 1'b0;
        @(posedge clk); #1;
        total_n++;
        if ({bus_err, stall_req, bus.bus_req} !== 3'b000)
            $display("FAIL timeout_pulse got=%b%b%b want=000",
                     bus_err, stall_req, bus.bus_req);
        else pass_n++;
    endtask

    task automatic test_rst_mid;
        mem_re = 1'b1;
        mem_f3 = 3'b010;
        addr   = 32'h5000;
        @(posedge clk); #1;
        rst    = 1'b1;
        mem_re = 1'b0;
        #1;
        total_n++;
        if (bus.bus_req !== 1'b0)
            $display("FAIL rst_req_now got=%b want=0", bus.bus_req);
        else pass_n++;
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(1, 0, 3'b010, 32'h5004, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, "pre");
        mem_re = 1'b1;
        addr   = 32'h5008;
        @(posedge clk); #1;
        bus.bus_ack = 1'b1;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        rst    = 1'b1;
        mem_re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        total_n++;
        if ({stall_req, misalign, bus_err, ld_data, bus.bus_req,
             bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata} !== '0)
            $display("FAIL rst_rwait got=%b%b%b %h %b%b %h %b %h want=0",
                     stall_req, misalign, bus_err, ld_data, bus.bus_req,
                     bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata);
        else pass_n++;
        exp_ld = '0;
        bus.bus_rvalid = 1'b1;
        bus.bus_rdata  = 32'h1111_2222;
        @(posedge clk); #1;
        bus.bus_rvalid = 1'b0;
        @(posedge clk); #1;
        total_n++;
        if ({stall_req, bus.bus_req, ld_data} !== 34'h0)
            $display("FAIL late_rvalid got=%b%b %h want=00 0",
                     stall_req, bus.bus_req, ld_data);
        else pass_n++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            bit re = 1'($urandom % 2);
            bit wr = re ? 1'($urandom % 2) : 1'b1;
            do_access(re, wr, 3'($urandom % 8), $urandom, $urandom,
                      $urandom, $urandom % 4, $urandom % 4, $urandom % 3,
                      "rand");
        end
    endtask

    initial begin
        bus.bus_ack    = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata  = '0;
        test_reset();
        test_directed();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
